pll_lock_sequencer: RTL and testbench

- Controls startup of the iCE40 PLL wrapper (SB_PLL40_PAD) and supervises it afterwards.
- Sequence: holds the PLL in reset, waits for LOCK, and requires LOCK to stay high for a qualification window before releasing the design reset.
- Retries the PLL on lock timeout and falls back to PLL bypass after repeated failure.
- Runs on the board reference clock, not the PLL output; sits beside the pll module in the top-level glue.

---
 rtl/pll_seq_pkg.sv | 17 +
 rtl/sync_2ff.sv | 32 +++
 rtl/pll_lock_sequencer.sv | 159 +++++++++++++++
 tb/tb_pll_lock_sequencer.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pll_seq_pkg.sv
// Shared definitions for the PLL lock sequencer.
// Contents: state encoding, which is also driven out on state_dbg, and the
// widths of the state and retry counter fields.
package pll_seq_pkg;

   localparam int STATE_W = 3;
   localparam int RETRY_W = 4;

   typedef enum logic [STATE_W-1:0] {
      PLL_RST   = 3'd0,
      WAIT_LOCK = 3'd1,
      STABLE    = 3'd2,
      RUN       = 3'd3,
      FAIL      = 3'd4
   } pll_state_t;

endpackage : pll_seq_pkg

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous level inputs.
// Ports:
//   clock : destination clock
//   reset : synchronous active-high clear of both stages
//   d     : asynchronous input bus (each bit is synchronized independently)
//   q     : synchronized output, two clock cycles behind d
module sync_2ff #(
   parameter int WIDTH = 1
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] meta_r;
   logic [WIDTH-1:0] sync_r;

   // Two register stages; the first may go metastable, the second settles it.
   always_ff @(posedge clock) begin
      if (reset) begin
         meta_r <= '0;
         sync_r <= '0;
      end else begin
         meta_r <= d;
         sync_r <= meta_r;
      end
   end

   assign q = sync_r;

endmodule : sync_2ff

// File: rtl/pll_lock_sequencer.sv
// PLL startup and supervision sequencer, clocked by the board reference clock.
// Holds the PLL in reset, waits for LOCK, qualifies it for a stable window and
// then releases the design reset. Retries the PLL on lock timeout and falls
// back to bypass (or stays in reset) after the retry budget is spent.
// Ports:
//   clock        : reference clock
//   reset        : synchronous active-high reset
//   pll_lock     : PLL LOCK, asynchronous to clock
//   pll_resetb   : PLL RESETB, active-low
//   pll_bypass   : PLL BYPASS
//   design_reset : active-high reset for the PLL clock domain logic
//   ready        : high only in RUN
//   error        : high only in FAIL
//   lock_lost    : sticky flag, set when lock drops while running
//   retry_count  : attempts made beyond the first
//   state_dbg    : current state encoding
module pll_lock_sequencer
   import pll_seq_pkg::*;
#(
   parameter int RESET_CYCLES   = 16,
   parameter int LOCK_TIMEOUT   = 65536,
   parameter int STABLE_CYCLES  = 1024,
   parameter int MAX_RETRIES    = 3,
   parameter int BYPASS_ON_FAIL = 1,
   parameter int CNT_W          = 17
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               pll_lock,
   output logic               pll_resetb,
   output logic               pll_bypass,
   output logic               design_reset,
   output logic               ready,
   output logic               error,
   output logic               lock_lost,
   output logic [RETRY_W-1:0] retry_count,
   output logic [STATE_W-1:0] state_dbg
);

   localparam logic [CNT_W-1:0]   RST_LAST     = CNT_W'(RESET_CYCLES - 1);
   localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
   localparam logic [CNT_W-1:0]   STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
   localparam logic [RETRY_W-1:0] RETRY_MAX    = RETRY_W'(MAX_RETRIES);
   localparam logic               BYPASS_EN    = (BYPASS_ON_FAIL != 0);

   pll_state_t         state_r;
   pll_state_t         state_s;
   logic [CNT_W-1:0]   cnt_r;
   logic [CNT_W-1:0]   cnt_s;
   logic [RETRY_W-1:0] retry_r;
   logic [RETRY_W-1:0] retry_s;
   logic               lost_r;
   logic               lost_s;
   logic [0:0]         lock_s;

   sync_2ff #(
      .WIDTH (1)
   ) u_lock_sync (
      .clock (clock),
      .reset (reset),
      .d     (pll_lock),
      .q     (lock_s)
   );

   // Next-state, counter, retry and sticky-flag logic.
   always_comb begin
      state_s = state_r;
      cnt_s   = cnt_r;
      retry_s = retry_r;
      lost_s  = lost_r;
      case (state_r)
         PLL_RST: begin
            if (cnt_r == RST_LAST) begin
               cnt_s   = '0;
               state_s = WAIT_LOCK;
            end else begin
               cnt_s = cnt_r + 1'b1;
            end
         end
         WAIT_LOCK: begin
            // Lock takes priority over a timeout in the same cycle.
            if (lock_s[0]) begin
               cnt_s   = '0;
               state_s = STABLE;
            end else if (cnt_r == TIMEOUT_LAST) begin
               cnt_s = '0;
               // Retry budget exhausted: retry_r never exceeds RETRY_MAX.
               if (retry_r == RETRY_MAX) begin
                  state_s = FAIL;
               end else begin
                  retry_s = retry_r + 1'b1;
                  state_s = PLL_RST;
               end
            end else begin
               cnt_s = cnt_r + 1'b1;
            end
         end
         STABLE: begin
            if (!lock_s[0]) begin
               cnt_s   = '0;
               state_s = WAIT_LOCK;
            end else if (cnt_r == STABLE_LAST) begin
               cnt_s   = '0;
               state_s = RUN;
            end else begin
               cnt_s = cnt_r + 1'b1;
            end
         end
         RUN: begin
            // Lock loss re-qualifies without resetting the PLL.
            if (!lock_s[0]) begin
               cnt_s   = '0;
               lost_s  = 1'b1;
               state_s = WAIT_LOCK;
            end else begin
               cnt_s = cnt_r;
            end
         end
         FAIL: begin
            state_s = FAIL;
         end
         default: begin
            cnt_s   = '0;
            state_s = PLL_RST;
         end
      endcase
   end

   // State/counter registers; outputs are registered from the next state so
   // they change in the same cycle the new state becomes visible.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_r      <= PLL_RST;
         cnt_r        <= '0;
         retry_r      <= '0;
         lost_r       <= 1'b0;
         pll_resetb   <= 1'b0;
         pll_bypass   <= 1'b0;
         design_reset <= 1'b1;
         ready        <= 1'b0;
         error        <= 1'b0;
      end else begin
         state_r      <= state_s;
         cnt_r        <= cnt_s;
         retry_r      <= retry_s;
         lost_r       <= lost_s;
         pll_resetb   <= (state_s != PLL_RST);
         pll_bypass   <= (state_s == FAIL) && BYPASS_EN;
         design_reset <= !((state_s == RUN) || ((state_s == FAIL) && BYPASS_EN));
         ready        <= (state_s == RUN);
         error        <= (state_s == FAIL);
      end
   end

   assign lock_lost   = lost_r;
   assign retry_count = retry_r;
   assign state_dbg   = state_r;

endmodule : pll_lock_sequencer

// File: tb/tb_pll_lock_sequencer.sv
// Self-checking bench for pll_lock_sequencer. Two instances share stimulus:
// dut_a falls back to bypass on failure, dut_b stays in reset.
module tb_pll_lock_sequencer;

   localparam int RC = 4;
   localparam int LT = 32;
   localparam int SC = 8;
   localparam int MR = 2;

   localparam int M_RST    = 0;
   localparam int M_WAIT   = 1;
   localparam int M_STABLE = 2;
   localparam int M_RUN    = 3;
   localparam int M_FAIL   = 4;

   // {pll_resetb, pll_bypass, design_reset, ready, error, lock_lost, retry[3:0], state[2:0]}
   localparam logic [12:0] RST_VEC = 13'b0_0_1_0_0_0_0000_000;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       pll_lock = 1'b0;

   logic       a_pll_resetb, a_pll_bypass, a_design_reset, a_ready, a_error, a_lock_lost;
   logic [3:0] a_retry_count;
   logic [2:0] a_state_dbg;
   logic       b_pll_resetb, b_pll_bypass, b_design_reset, b_ready, b_error, b_lock_lost;
   logic [3:0] b_retry_count;
   logic [2:0] b_state_dbg;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;

   int m_mode [2];
   int m_elapsed [2];
   int m_retry [2];
   bit m_lost [2];
   bit m_s1 [2];
   bit m_s2 [2];

   always #5 clock = ~clock;

   pll_lock_sequencer #(
      .RESET_CYCLES (RC), .LOCK_TIMEOUT (LT), .STABLE_CYCLES (SC),
      .MAX_RETRIES (MR), .BYPASS_ON_FAIL (1), .CNT_W (17)
   ) dut_a (
      .clock (clock), .reset (reset), .pll_lock (pll_lock),
      .pll_resetb (a_pll_resetb), .pll_bypass (a_pll_bypass),
      .design_reset (a_design_reset), .ready (a_ready), .error (a_error),
      .lock_lost (a_lock_lost), .retry_count (a_retry_count), .state_dbg (a_state_dbg)
   );

   pll_lock_sequencer #(
      .RESET_CYCLES (RC), .LOCK_TIMEOUT (LT), .STABLE_CYCLES (SC),
      .MAX_RETRIES (MR), .BYPASS_ON_FAIL (0), .CNT_W (17)
   ) dut_b (
      .clock (clock), .reset (reset), .pll_lock (pll_lock),
      .pll_resetb (b_pll_resetb), .pll_bypass (b_pll_bypass),
      .design_reset (b_design_reset), .ready (b_ready), .error (b_error),
      .lock_lost (b_lock_lost), .retry_count (b_retry_count), .state_dbg (b_state_dbg)
   );

   function automatic logic [12:0] vec_a();
      return {a_pll_resetb, a_pll_bypass, a_design_reset, a_ready, a_error,
              a_lock_lost, a_retry_count, a_state_dbg};
   endfunction

   function automatic logic [12:0] vec_b();
      return {b_pll_resetb, b_pll_bypass, b_design_reset, b_ready, b_error,
              b_lock_lost, b_retry_count, b_state_dbg};
   endfunction

   // Advance the reference model by one clock edge with the inputs seen there.
   task automatic model_step(input bit rst, input bit lk);
      bit ls;
      for (int k = 0; k < 2; k++) begin
         if (rst) begin
            m_mode[k] = M_RST; m_elapsed[k] = 0; m_retry[k] = 0;
            m_lost[k] = 1'b0; m_s1[k] = 1'b0; m_s2[k] = 1'b0;
         end else begin
            ls = m_s2[k];
            m_s2[k] = m_s1[k];
            m_s1[k] = lk;
            case (m_mode[k])
               M_RST: begin
                  m_elapsed[k]++;
                  if (m_elapsed[k] == RC) begin m_mode[k] = M_WAIT; m_elapsed[k] = 0; end
               end
               M_WAIT: begin
                  if (ls) begin
                     m_mode[k] = M_STABLE; m_elapsed[k] = 0;
                  end else begin
                     m_elapsed[k]++;
                     if (m_elapsed[k] == LT) begin
                        m_elapsed[k] = 0;
                        if (m_retry[k] == MR) m_mode[k] = M_FAIL;
                        else begin m_retry[k]++; m_mode[k] = M_RST; end
                     end
                  end
               end
               M_STABLE: begin
                  if (!ls) begin
                     m_mode[k] = M_WAIT; m_elapsed[k] = 0;
                  end else begin
                     m_elapsed[k]++;
                     if (m_elapsed[k] == SC) begin m_mode[k] = M_RUN; m_elapsed[k] = 0; end
                  end
               end
               M_RUN: begin
                  if (!ls) begin m_mode[k] = M_WAIT; m_elapsed[k] = 0; m_lost[k] = 1'b1; end
               end
               default: ;
            endcase
         end
      end
   endtask

   function automatic logic [12:0] exp_vec(input int k);
      bit byp;
      bit f;
      byp = (k == 0);
      f   = (m_mode[k] == M_FAIL);
      return {m_mode[k] != M_RST, f && byp, !((m_mode[k] == M_RUN) || (f && byp)),
              m_mode[k] == M_RUN, f, m_lost[k], 4'(m_retry[k]), 3'(m_mode[k])};
   endfunction

   task automatic compare_all();
      logic [12:0] act;
      logic [12:0] exp;
      for (int k = 0; k < 2; k++) begin
         act = (k == 0) ? vec_a() : vec_b();
         exp = exp_vec(k);
         n_cmp++;
         if (act !== exp) begin
            n_bad++;
            $display("FAIL model_cmp dut%0d cycle %0d: got %b required %b", k, cyc, act, exp);
         end
      end
   endtask

   task automatic pin(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s cycle %0d: got %0h required %0h", name, cyc, act, exp);
      end
   endtask

   // One clock: apply inputs, let the edge happen, step the model, check.
   task automatic step(input bit rst, input bit lk);
      reset    = rst;
      pll_lock = lk;
      @(posedge clock);
      model_step(rst, lk);
      #2;
      if (rst) cyc = 0;
      else cyc++;
      compare_all();
   endtask

   initial begin
      // Lock from cycle 10; later a 3-cycle drop while running (cycles 30-32).
      step(1'b1, 1'b0);
      pin("reset_state", vec_a(), RST_VEC);
      while (cyc < 60) begin
         step(1'b0, (cyc >= 10) && !((cyc >= 30) && (cyc < 33)));
         case (cyc)
            3:  pin("resetb_low_c3", a_pll_resetb, 0);
            4:  pin("resetb_high_c4", a_pll_resetb, 1);
            20: pin("ready_c20", a_ready, 0);
            21: begin
               pin("ready_c21", a_ready, 1);
               pin("dreset_c21", a_design_reset, 0);
            end
            32: pin("ready_c32", a_ready, 1);
            33: begin
               pin("dreset_c33", a_design_reset, 1);
               pin("lost_c33", a_lock_lost, 1);
               pin("resetb_c33", a_pll_resetb, 1);
               pin("state_c33", a_state_dbg, 1);
            end
            43: pin("ready_c43", a_ready, 0);
            44: begin
               pin("ready_c44", a_ready, 1);
               pin("lost_c44", a_lock_lost, 1);
               pin("retry_c44", a_retry_count, 0);
            end
            default: ;
         endcase
      end
      step(1'b1, 1'b1);
      pin("reset_in_run", vec_a(), RST_VEC);

      // Single-cycle lock glitch at cycle 15 during qualification.
      while (cyc < 35) begin
         step(1'b0, (cyc >= 10) && (cyc != 15));
         case (cyc)
            18: pin("state_c18", a_state_dbg, 1);
            26: pin("ready_c26", a_ready, 0);
            27: begin
               pin("ready_c27", a_ready, 1);
               pin("retry_c27", a_retry_count, 0);
            end
            default: ;
         endcase
      end

      // No lock at all: three attempts then FAIL; lock afterwards is ignored.
      step(1'b1, 1'b0);
      while (cyc < 115) begin
         step(1'b0, 1'b0);
         case (cyc)
            35: pin("state_c35", a_state_dbg, 1);
            36: begin
               pin("state_c36", a_state_dbg, 0);
               pin("retry_c36", a_retry_count, 1);
            end
            72:  pin("retry_c72", a_retry_count, 2);
            107: pin("error_c107", a_error, 0);
            108: begin
               pin("state_c108", a_state_dbg, 4);
               pin("error_a_c108", a_error, 1);
               pin("bypass_a_c108", a_pll_bypass, 1);
               pin("dreset_a_c108", a_design_reset, 0);
               pin("ready_a_c108", a_ready, 0);
               pin("retry_a_c108", a_retry_count, 2);
               pin("error_b_c108", b_error, 1);
               pin("bypass_b_c108", b_pll_bypass, 0);
               pin("dreset_b_c108", b_design_reset, 1);
            end
            default: ;
         endcase
      end
      repeat (10) step(1'b0, 1'b1);
      pin("fail_sticky", a_state_dbg, 4);
      step(1'b1, 1'b1);
      pin("reset_in_fail_a", vec_a(), RST_VEC);
      pin("reset_in_fail_b", vec_b(), RST_VEC);
      step(1'b0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule : tb_pll_lock_sequencer
